// File: rtl/cpu_core_pkg.sv
// Shared definitions for the small accumulator core: FSM states, opcode and
// ALU/jump sub-field encodings, STATUS bit positions and the branch condition.
package cpu_core_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_IRQ,
        S_FAULT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_LDF  = 4'd2;
    localparam logic [3:0] OP_STF  = 4'd3;
    localparam logic [3:0] OP_ALUI = 4'd4;
    localparam logic [3:0] OP_ALUF = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_CALL = 4'd7;
    localparam logic [3:0] OP_RET  = 4'd8;
    localparam logic [3:0] OP_RETI = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;

    localparam logic [3:0] JC_ALWAYS = 4'd0;
    localparam logic [3:0] JC_Z      = 4'd1;
    localparam logic [3:0] JC_C      = 4'd2;
    localparam logic [3:0] JC_N      = 4'd3;

    localparam int STATUS_W = 3;
    localparam int ST_Z = 0;
    localparam int ST_C = 1;
    localparam int ST_N = 2;

    // Unknown condition codes report "not taken"; the core faults on them separately.
    function automatic logic jump_taken(input logic [3:0] sub, input logic [STATUS_W-1:0] st);
        logic taken;
        case (sub)
            JC_ALWAYS: taken = 1'b1;
            JC_Z:      taken = st[ST_Z];
            JC_C:      taken = st[ST_C];
            JC_N:      taken = st[ST_N];
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/cpu_stack.sv
// Return-address stack. sp counts stored entries, so sp==DEPTH means full;
// pushes when full and pops when empty are ignored and left to the caller to trap.
module cpu_stack #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   ONE_S   = 1;
    localparam logic [AW-1:0] ONE_A   = 1;
    localparam logic [AW:0]   FULL_SP = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      sp_q;
    logic [AW-1:0]    top_idx;

    assign full     = (sp_q == FULL_SP);
    assign empty    = (sp_q == '0);
    assign top_idx  = sp_q[AW-1:0] - ONE_A;
    assign top_data = mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else if (clear) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + ONE_S;
        end else if (pop && !empty) begin
            sp_q <= sp_q - ONE_S;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cpu_core.sv
// Two-cycle-per-instruction accumulator core with file registers, a return
// stack, one level of interrupt nesting and a sticky FAULT state.
module cpu_core
    import cpu_core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W = 8,
    parameter int STACK_DEPTH = 16,
    parameter logic [PC_W-1:0] IRQ_VEC = 8'hF0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [PC_W-1:0]   i_waddr,
    input  logic [DATA_W+7:0] i_instr,
    input  logic              i_start,
    input  logic              i_irq,
    output logic              o_irq_ack,
    output logic              o_busy,
    output logic              o_fault,
    output logic [PC_W-1:0]   o_pc,
    output logic [DATA_W-1:0] o_WREG
);

    localparam int INSTR_W    = DATA_W + 8;
    localparam int IMEM_DEPTH = 2 ** PC_W;
    localparam int FR_DEPTH   = 2 ** DATA_W;
    localparam logic [PC_W-1:0] PC_ONE = 1;

    logic [INSTR_W-1:0] imem  [IMEM_DEPTH];
    logic [DATA_W-1:0]  fregs [FR_DEPTH];

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q;
    logic [DATA_W-1:0]   wreg_q;
    logic [STATUS_W-1:0] status_q;
    logic                in_isr_q;
    logic [INSTR_W-1:0]  ir_q;

    logic [3:0]        opcode, sub;
    logic [DATA_W-1:0] imm, fr_rd, alu_b;
    logic [DATA_W:0]   alu_wide;
    logic              alu_bad;
    logic [PC_W-1:0]   pc_inc;
    logic              irq_take;

    logic [PC_W-1:0]     pc_exec;
    logic [DATA_W-1:0]   wreg_exec;
    logic [STATUS_W-1:0] status_exec;
    logic                exec_fault, exec_halt, fr_we, push_exec, pop_exec, isr_exit;

    logic            stk_push, stk_pop, stk_clear, stk_full, stk_empty;
    logic [PC_W-1:0] stk_push_data, stk_top;

    assign opcode   = ir_q[INSTR_W-1 -: 4];
    assign sub      = ir_q[INSTR_W-5 -: 4];
    assign imm      = ir_q[DATA_W-1:0];
    assign fr_rd    = fregs[imm];
    assign alu_b    = (opcode == OP_ALUF) ? fr_rd : imm;
    assign pc_inc   = pc_q + PC_ONE;
    assign irq_take = i_irq && !in_isr_q;
    assign stk_clear = (state_q == S_IDLE) && i_start;

    cpu_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_stack (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (stk_push_data),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Bit DATA_W carries the ADD carry-out or the SUB borrow; logic ops leave it clear.
    always_comb begin
        alu_wide = '0;
        alu_bad  = 1'b0;
        case (sub)
            ALU_ADD: alu_wide = {1'b0, wreg_q} + {1'b0, alu_b};
            ALU_SUB: alu_wide = {1'b0, wreg_q} - {1'b0, alu_b};
            ALU_AND: alu_wide = {1'b0, wreg_q & alu_b};
            ALU_OR:  alu_wide = {1'b0, wreg_q | alu_b};
            ALU_XOR: alu_wide = {1'b0, wreg_q ^ alu_b};
            default: alu_bad  = 1'b1;
        endcase
    end

    always_comb begin
        pc_exec     = pc_inc;
        wreg_exec   = wreg_q;
        status_exec = status_q;
        exec_fault  = 1'b0;
        exec_halt   = 1'b0;
        fr_we       = 1'b0;
        push_exec   = 1'b0;
        pop_exec    = 1'b0;
        isr_exit    = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_LDI: wreg_exec = imm;
            OP_LDF: wreg_exec = fr_rd;
            OP_STF: fr_we = 1'b1;
            OP_ALUI, OP_ALUF: begin
                if (alu_bad) begin
                    exec_fault = 1'b1;
                end else begin
                    wreg_exec          = alu_wide[DATA_W-1:0];
                    status_exec[ST_Z]  = (alu_wide[DATA_W-1:0] == '0);
                    status_exec[ST_C]  = alu_wide[DATA_W];
                    status_exec[ST_N]  = alu_wide[DATA_W-1];
                end
            end
            OP_JMP: begin
                if (sub > JC_N) begin
                    exec_fault = 1'b1;
                end else if (jump_taken(sub, status_q)) begin
                    pc_exec = imm[PC_W-1:0];
                end
            end
            OP_CALL: begin
                if (stk_full) begin
                    exec_fault = 1'b1;
                end else begin
                    push_exec = 1'b1;
                    pc_exec   = imm[PC_W-1:0];
                end
            end
            OP_RET, OP_RETI: begin
                if (stk_empty) begin
                    exec_fault = 1'b1;
                end else begin
                    pop_exec = 1'b1;
                    isr_exit = (opcode == OP_RETI);
                    pc_exec  = stk_top;
                end
            end
            OP_HALT: begin
                exec_halt = 1'b1;
                pc_exec   = pc_q;
            end
            default: exec_fault = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_FETCH;
            S_FETCH: state_d = irq_take ? S_IRQ : S_EXEC;
            S_EXEC: begin
                if (exec_fault) begin
                    state_d = S_FAULT;
                end else if (exec_halt) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_IRQ:   state_d = stk_full ? S_FAULT : S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    always_comb begin
        o_busy        = (state_q != S_IDLE) && (state_q != S_FAULT);
        o_fault       = (state_q == S_FAULT);
        o_irq_ack     = (state_q == S_IRQ) && !stk_full;
        stk_push      = ((state_q == S_EXEC) && push_exec) || ((state_q == S_IRQ) && !stk_full);
        stk_pop       = (state_q == S_EXEC) && pop_exec;
        stk_push_data = (state_q == S_IRQ) ? pc_q : pc_inc;
    end

    // A faulting instruction commits nothing, so the machine freezes exactly where it trapped.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc_q     <= '0;
            wreg_q   <= '0;
            status_q <= '0;
            in_isr_q <= 1'b0;
            ir_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        pc_q     <= '0;
                        wreg_q   <= '0;
                        status_q <= '0;
                        in_isr_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (!irq_take) begin
                        ir_q <= imem[pc_q];
                    end
                end
                S_IRQ: begin
                    if (!stk_full) begin
                        pc_q     <= IRQ_VEC;
                        in_isr_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!exec_fault) begin
                        pc_q     <= pc_exec;
                        wreg_q   <= wreg_exec;
                        status_q <= status_exec;
                        if (isr_exit) begin
                            in_isr_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if ((state_q == S_IDLE) && i_we) begin
            imem[i_waddr] <= i_instr;
        end
        if ((state_q == S_EXEC) && fr_we) begin
            fregs[imm] <= wreg_q;
        end
    end

    assign o_pc   = pc_q;
    assign o_WREG = wreg_q;

endmodule

// File: tb/tb_cpu_core.sv
// Directed self-checking bench for cpu_core: each task loads a small program,
// runs it and compares outputs against hand-computed results.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  waddr = '0;
    logic [15:0] instr = '0;
    logic        start = 1'b0;
    logic        irq = 1'b0;
    logic        irq_ack, busy, fault;
    logic [7:0]  pc, wreg;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cpu_core #(
        .DATA_W      (8),
        .PC_W        (8),
        .STACK_DEPTH (16),
        .IRQ_VEC     (8'hF0)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_we      (we),
        .i_waddr   (waddr),
        .i_instr   (instr),
        .i_start   (start),
        .i_irq     (irq),
        .o_irq_ack (irq_ack),
        .o_busy    (busy),
        .o_fault   (fault),
        .o_pc      (pc),
        .o_WREG    (wreg)
    );

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] sb, input logic [7:0] imm);
        return {op, sb, imm};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        start = 1'b0;
        we    = 1'b0;
        irq   = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        we    = 1'b1;
        waddr = a;
        instr = d;
        tick(1);
        we    = 1'b0;
    endtask

    task automatic clear_imem;
        for (int a = 0; a < 256; a++) begin
            poke(a[7:0], 16'hF000);
        end
    endtask

    // Leaves the bench one cycle after the start edge, with the core in its first FETCH.
    task automatic run;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_stop(input string name, input int limit);
        int c;
        c = 0;
        while (busy && c < limit) begin
            tick(1);
            c++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, limit);
        end
    endtask

    task automatic test_reset;
        do_reset();
        total += 5;
        if (pc !== 8'h00)    begin bad++; $display("[TB] FAIL reset_pc: got %h want 00", pc); end
        if (wreg !== 8'h00)  begin bad++; $display("[TB] FAIL reset_wreg: got %h want 00", wreg); end
        if (busy !== 1'b0)   begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        if (fault !== 1'b0)  begin bad++; $display("[TB] FAIL reset_fault: got %b want 0", fault); end
        if (irq_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", irq_ack); end
    endtask

    // Also drives program writes while running; they must be ignored outside IDLE.
    task automatic test_basic;
        do_reset();
        clear_imem();
        poke(8'h00, ins(4'd1, 4'd0, 8'h05));
        poke(8'h01, ins(4'd4, 4'd0, 8'h03));
        poke(8'h02, ins(4'd15, 4'd0, 8'h00));
        run();
        we    = 1'b1;
        waddr = 8'h02;
        instr = ins(4'd1, 4'd0, 8'h99);
        tick(5);
        total++;
        if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy5: got %b want 1", busy); end
        tick(1);
        we = 1'b0;
        total += 4;
        if (busy !== 1'b0)         begin bad++; $display("[TB] FAIL basic_busy6: got %b want 0", busy); end
        if (wreg !== 8'h08)        begin bad++; $display("[TB] FAIL basic_wreg: got %h want 08", wreg); end
        if (dut.status_q !== 3'b000) begin bad++; $display("[TB] FAIL basic_status: got %b want 000", dut.status_q); end
        if (pc !== 8'h02)          begin bad++; $display("[TB] FAIL basic_pc: got %h want 02", pc); end
    endtask

    task automatic test_jump;
        do_reset();
        clear_imem();
        poke(8'h00, ins(4'd1, 4'd0, 8'hFF));
        poke(8'h01, ins(4'd4, 4'd0, 8'h01));
        poke(8'h02, ins(4'd6, 4'd3, 8'h30));
        poke(8'h03, ins(4'd6, 4'd1, 8'h10));
        run();
        wait_stop("jump", 40);
        total += 4;
        if (wreg !== 8'h00)          begin bad++; $display("[TB] FAIL jump_wreg: got %h want 00", wreg); end
        if (dut.status_q !== 3'b011) begin bad++; $display("[TB] FAIL jump_status: got %b want 011", dut.status_q); end
        if (pc !== 8'h10)            begin bad++; $display("[TB] FAIL jump_pc: got %h want 10", pc); end
        if (fault !== 1'b0)          begin bad++; $display("[TB] FAIL jump_fault: got %b want 0", fault); end
    endtask

    task automatic test_alu;
        do_reset();
        clear_imem();
        poke(8'h00, ins(4'd1, 4'd0, 8'h03));
        poke(8'h01, ins(4'd4, 4'd1, 8'h05));
        poke(8'h02, ins(4'd3, 4'd0, 8'h40));
        poke(8'h03, ins(4'd1, 4'd0, 8'h0F));
        poke(8'h04, ins(4'd5, 4'd2, 8'h40));
        poke(8'h05, ins(4'd4, 4'd4, 8'h0E));
        poke(8'h06, ins(4'd4, 4'd3, 8'h80));
        poke(8'h07, ins(4'd2, 4'd0, 8'h40));
        run();
        tick(4);
        total += 2;
        if (wreg !== 8'hFE)          begin bad++; $display("[TB] FAIL alu_sub_wreg: got %h want fe", wreg); end
        if (dut.status_q !== 3'b110) begin bad++; $display("[TB] FAIL alu_sub_status: got %b want 110", dut.status_q); end
        wait_stop("alu", 60);
        total += 3;
        if (wreg !== 8'hFE)          begin bad++; $display("[TB] FAIL alu_wreg: got %h want fe", wreg); end
        if (dut.status_q !== 3'b100) begin bad++; $display("[TB] FAIL alu_status: got %b want 100", dut.status_q); end
        if (pc !== 8'h08)            begin bad++; $display("[TB] FAIL alu_pc: got %h want 08", pc); end
    endtask

    task automatic test_call;
        do_reset();
        clear_imem();
        poke(8'h00, ins(4'd7, 4'd0, 8'h20));
        poke(8'h20, ins(4'd1, 4'd0, 8'h07));
        poke(8'h21, ins(4'd8, 4'd0, 8'h00));
        run();
        tick(2);
        total += 2;
        if (pc !== 8'h20)              begin bad++; $display("[TB] FAIL call_pc: got %h want 20", pc); end
        if (dut.u_stack.sp_q !== 5'd1) begin bad++; $display("[TB] FAIL call_sp: got %0d want 1", dut.u_stack.sp_q); end
        wait_stop("call", 40);
        total += 3;
        if (wreg !== 8'h07)            begin bad++; $display("[TB] FAIL ret_wreg: got %h want 07", wreg); end
        if (pc !== 8'h01)              begin bad++; $display("[TB] FAIL ret_pc: got %h want 01", pc); end
        if (dut.u_stack.sp_q !== 5'd0) begin bad++; $display("[TB] FAIL ret_sp: got %0d want 0", dut.u_stack.sp_q); end
    endtask

    task automatic test_irq;
        int acks;
        do_reset();
        clear_imem();
        for (int a = 0; a < 4; a++) poke(a[7:0], ins(4'd0, 4'd0, 8'h00));
        poke(8'hF0, ins(4'd0, 4'd0, 8'h00));
        poke(8'hF1, ins(4'd9, 4'd0, 8'h00));
        run();
        tick(7);
        total++;
        if (pc !== 8'h03) begin bad++; $display("[TB] FAIL irq_pre_pc: got %h want 03", pc); end
        irq = 1'b1;
        tick(1);
        total += 2;
        if (irq_ack !== 1'b0) begin bad++; $display("[TB] FAIL irq_early_ack: got %b want 0", irq_ack); end
        if (pc !== 8'h04)     begin bad++; $display("[TB] FAIL irq_finish_pc: got %h want 04", pc); end
        tick(1);
        total++;
        if (irq_ack !== 1'b1) begin bad++; $display("[TB] FAIL irq_ack: got %b want 1", irq_ack); end
        tick(1);
        total += 2;
        if (irq_ack !== 1'b0) begin bad++; $display("[TB] FAIL irq_ack_pulse: got %b want 0", irq_ack); end
        if (pc !== 8'hF0)     begin bad++; $display("[TB] FAIL irq_vec_pc: got %h want f0", pc); end
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (irq_ack) acks++;
        end
        total += 2;
        if (acks !== 0)   begin bad++; $display("[TB] FAIL irq_nested: got %0d acks want 0", acks); end
        if (pc !== 8'h04) begin bad++; $display("[TB] FAIL reti_pc: got %h want 04", pc); end
        tick(1);
        irq = 1'b0;
        total++;
        if (irq_ack !== 1'b1) begin bad++; $display("[TB] FAIL irq_reenter: got %b want 1", irq_ack); end
        wait_stop("irq", 40);
        total += 2;
        if (pc !== 8'h04)    begin bad++; $display("[TB] FAIL irq_end_pc: got %h want 04", pc); end
        if (fault !== 1'b0)  begin bad++; $display("[TB] FAIL irq_fault: got %b want 0", fault); end
    endtask

    task automatic test_overflow;
        do_reset();
        clear_imem();
        poke(8'h00, ins(4'd7, 4'd0, 8'h00));
        run();
        wait_stop("overflow", 100);
        total += 4;
        if (fault !== 1'b1)             begin bad++; $display("[TB] FAIL ovf_fault: got %b want 1", fault); end
        if (busy !== 1'b0)              begin bad++; $display("[TB] FAIL ovf_busy: got %b want 0", busy); end
        if (dut.u_stack.sp_q !== 5'd16) begin bad++; $display("[TB] FAIL ovf_sp: got %0d want 16", dut.u_stack.sp_q); end
        if (pc !== 8'h00)               begin bad++; $display("[TB] FAIL ovf_pc: got %h want 00", pc); end
        start = 1'b1;
        tick(3);
        start = 1'b0;
        total += 2;
        if (fault !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky: got %b want 1", fault); end
        if (busy !== 1'b0)  begin bad++; $display("[TB] FAIL ovf_restart_busy: got %b want 0", busy); end
    endtask

    task automatic test_faults;
        logic [15:0] vec [4];
        vec[0] = ins(4'd8, 4'd0, 8'h00);
        vec[1] = ins(4'd10, 4'd0, 8'h00);
        vec[2] = ins(4'd4, 4'd5, 8'h01);
        vec[3] = ins(4'd6, 4'd4, 8'h10);
        for (int i = 0; i < 4; i++) begin
            do_reset();
            poke(8'h00, vec[i]);
            run();
            wait_stop("fault", 20);
            total += 3;
            if (fault !== 1'b1) begin bad++; $display("[TB] FAIL fault%0d_flag: got %b want 1", i, fault); end
            if (busy !== 1'b0)  begin bad++; $display("[TB] FAIL fault%0d_busy: got %b want 0", i, busy); end
            if (pc !== 8'h00)   begin bad++; $display("[TB] FAIL fault%0d_pc: got %h want 00", i, pc); end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        clear_imem();
        poke(8'h00, ins(4'd1, 4'd0, 8'h55));
        poke(8'h01, ins(4'd3, 4'd0, 8'h10));
        poke(8'h02, ins(4'd1, 4'd0, 8'h00));
        poke(8'h03, ins(4'd2, 4'd0, 8'h10));
        run();
        tick(3);
        rst_n = 1'b0;
        #1;
        total += 5;
        if (pc !== 8'h00)     begin bad++; $display("[TB] FAIL midrst_pc: got %h want 00", pc); end
        if (wreg !== 8'h00)   begin bad++; $display("[TB] FAIL midrst_wreg: got %h want 00", wreg); end
        if (busy !== 1'b0)    begin bad++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
        if (fault !== 1'b0)   begin bad++; $display("[TB] FAIL midrst_fault: got %b want 0", fault); end
        if (irq_ack !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ack: got %b want 0", irq_ack); end
        tick(1);
        rst_n = 1'b1;
        tick(1);
        run();
        wait_stop("midrst", 40);
        total += 2;
        if (wreg !== 8'h55) begin bad++; $display("[TB] FAIL midrst_rerun_wreg: got %h want 55", wreg); end
        if (pc !== 8'h04)   begin bad++; $display("[TB] FAIL midrst_rerun_pc: got %h want 04", pc); end
    endtask

    initial begin
        $display("[TB] starting cpu_core directed tests");
        test_reset();
        test_basic();
        test_jump();
        test_alu();
        test_call();
        test_irq();
        test_overflow();
        test_faults();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter DATA_W, default 8, width of WREG, immediate, file registers and ALU.
REQ-002 Parameter PC_W, default 8, program counter width; PC_W <= DATA_W; instruction memory depth 2**PC_W.
REQ-003 Parameter STACK_DEPTH, default 16, return-stack entries (power of two, >=2).
REQ-004 Parameter IRQ_VEC, default 8'hF0, interrupt entry address (PC_W bits).
REQ-005 Instruction width INSTR_W = 8+DATA_W: [INSTR_W-1:INSTR_W-4] opcode, [INSTR_W-5:DATA_W] sub, [DATA_W-1:0] imm.
REQ-006 i_clk  in  1  single clock; all state on rising edge.
REQ-007 i_rst  in  1  asynchronous, active-low reset.
REQ-008 i_we  in  1  program-write strobe; i_waddr in PC_W; i_instr in INSTR_W write data.
REQ-009 i_start  in  1  run request, sampled in IDLE only.
REQ-010 i_irq  in  1  level interrupt request.
REQ-011 o_irq_ack  out  1  one-cycle pulse when interrupt taken.
REQ-012 o_busy out 1 (state not IDLE/FAULT); o_fault out 1; o_pc out PC_W; o_WREG out DATA_W.

Function
REQ-013 States IDLE, FETCH, EXEC, IRQ, FAULT; each instruction costs FETCH+EXEC = 2 cycles.
REQ-014 IDLE: i_we writes imem[i_waddr]; writes ignored in all other states.
REQ-015 IDLE and i_start=1 -> FETCH with PC=0, stack pointer=0, WREG=0, STATUS=0, in_isr=0.
REQ-016 FETCH: if i_irq=1 and in_isr=0 -> IRQ; else register imem[PC] -> EXEC.
REQ-017 IRQ: stack full -> FAULT; else push PC, PC=IRQ_VEC, in_isr=1, o_irq_ack=1 -> FETCH.
REQ-018 EXEC opcodes (PC=PC+1 unless stated): 0 NOP; 1 LDI W=imm; 2 LDF W=FR[imm]; 3 STF FR[imm]=W.
REQ-019 4 ALUI W=W op imm; 5 ALUF W=W op FR[imm]; op by sub: 0 ADD,1 SUB,2 AND,3 OR,4 XOR; other sub -> FAULT.
REQ-020 ALU ops update STATUS {N,C,Z}: Z=(result==0), N=result MSB, C=carry-out (ADD) / borrow (SUB), C=0 for logic ops.
REQ-021 Arithmetic modulo 2**DATA_W; no saturation.
REQ-022 6 JMP: cond by sub 0 always,1 Z,2 C,3 N; taken -> PC=imm[PC_W-1:0]; other sub -> FAULT.
REQ-023 7 CALL: push PC+1, PC=imm; 8 RET: pop into PC; 9 RETI: pop into PC, in_isr=0.
REQ-024 15 HALT -> IDLE, PC held; opcodes 10-14 -> FAULT.
REQ-025 Push when SP==STACK_DEPTH -> FAULT, no write; pop when SP==0 -> FAULT.
REQ-026 PC wraps from 2**PC_W-1 to 0.
REQ-027 FAULT: o_fault=1, all state frozen; exit only via reset.
REQ-028 i_irq asserted during EXEC is taken at the next FETCH, after the current instruction completes.
REQ-029 o_pc and o_WREG reflect registered state.

Reset
REQ-030 Reset low -> IDLE, PC=0, SP=0, WREG=0, STATUS=0, in_isr=0, o_irq_ack=0, o_fault=0, o_busy=0, any cycle including mid-instruction.
REQ-031 Instruction memory and file registers not cleared by reset.

Structure
REQ-032 Shared package cpu_core_pkg: state enum, opcode and ALU-sub constants, STATUS bit indices.
REQ-033 Return stack is sub-module cpu_stack (push/pop/full/empty, parametrised depth/width); remainder flat.

Verification
REQ-034 Load LDI 5; ALUI ADD 3; HALT; start -> o_WREG=8, Z=0, o_busy low after 6 cycles.
REQ-035 LDI 8'hFF; ALUI ADD 1; JMP Z to 0x10 -> W=0, Z=1, C=1, PC=0x10.
REQ-036 CALL 0x20 (0x20: LDI 7; RET), then HALT at 1 -> W=7, PC returns to 1, SP=0.
REQ-037 i_irq high during EXEC of NOP at 3 -> o_irq_ack pulse, PC=IRQ_VEC; RETI -> PC=4; i_irq held high re-enters only after RETI.
REQ-038 STACK_DEPTH+1 nested CALLs -> o_fault=1, busy=0; RET at SP=0 -> o_fault=1; opcode 10 -> o_fault=1.
REQ-039 Reset asserted mid-EXEC of STF -> all outputs at reset values immediately; imem contents intact on restart.
